// File: rtl/ntt_stage_scheduler.sv
// ntt_stage_scheduler
//   Sequences a full radix-2 in-place NTT of N = 2^LOGN points through one
//   pipelined butterfly. It issues one x/y read pair and twiddle address per
//   ISSUE cycle, delays the read strobe to the butterfly enable and the write
//   strobe, and drains each stage before the next stage starts reading.
//
//   Parameters: LOGN (log2 N, 2..12), BF_LAT (butterfly latency),
//               RD_LAT (coefficient RAM / twiddle ROM read latency).
//   Ports:
//     clk, reset (async, active low), start (one-cycle request)
//     busy, done, stage                     - transform status
//     rd_en, rd_addr_x, rd_addr_y, tw_addr  - read side, same cycle
//     bf_en                                 - butterfly enable (rd_en + RD_LAT)
//     bf_valid                              - butterfly valid, cross-checked only
//     wr_en, wr_addr_x, wr_addr_y           - write side (rd + RD_LAT + BF_LAT)
//     err                                   - sticky bf_valid/wr_en disagreement
//   Optional build macro NTT_SCHED_STALL_EN adds input 'hold', which suppresses
//   issue for the ISSUE cycles it is high in; in-flight pairs keep moving.
module ntt_stage_scheduler #(
  parameter int  LOGN   = 3,
  parameter int  BF_LAT = 3,
  parameter int  RD_LAT = 1,
  localparam int TW_W   = (LOGN > 1) ? LOGN - 1 : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
`ifdef NTT_SCHED_STALL_EN
  input  logic            hold,
`endif
  output logic            busy,
  output logic            done,
  output logic [LOGN-1:0] stage,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_x,
  output logic [LOGN-1:0] rd_addr_y,
  output logic [TW_W-1:0] tw_addr,
  output logic            bf_en,
  input  logic            bf_valid,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_x,
  output logic [LOGN-1:0] wr_addr_y,
  output logic            err
);

  localparam int DLY = RD_LAT + BF_LAT;
  localparam int CW  = $clog2(DLY + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  localparam logic [TW_W-1:0] J_LAST = TW_W'((1 << (LOGN - 1)) - 1);
  localparam logic [LOGN-1:0] S_LAST = LOGN'(LOGN - 1);
  localparam logic [CW-1:0]   C_LAST = CW'(DLY - 1);

  logic [1:0]      state_r, state_nx_s;
  logic [LOGN-1:0] stage_r, stage_nx_s;
  logic [TW_W-1:0] j_r, j_nx_s;
  logic [CW-1:0]   cnt_r, cnt_nx_s;
  logic            issue_r, issue_s;
  logic            busy_r, done_r;
  logic [LOGN-1:0] rd_x_r, rd_y_r;
  logic [TW_W-1:0] tw_r;
  logic [DLY-1:0]  en_dly_r;
  logic [LOGN-1:0] x_dly_r [DLY];
  logic [LOGN-1:0] y_dly_r [DLY];
  logic            err_r;

  // Bits below the stage's butterfly span: half - 1 = 2^s - 1.
  function automatic logic [LOGN-1:0] low_mask(input logic [LOGN-1:0] s);
    return (LOGN'(1) << s) - LOGN'(1);
  endfunction

  // x = g*2*half + k is j with a zero bit inserted at position s.
  function automatic logic [LOGN-1:0] addr_x(input logic [LOGN-1:0] s,
                                             input logic [TW_W-1:0] j);
    logic [LOGN-1:0] je;
    logic [LOGN-1:0] m;
    je = LOGN'(j);
    m  = low_mask(s);
    return ((je & ~m) << 1'b1) | (je & m);
  endfunction

  // y = x + half; bit s of x is always zero so OR is an add.
  function automatic logic [LOGN-1:0] addr_y(input logic [LOGN-1:0] s,
                                             input logic [TW_W-1:0] j);
    return addr_x(s, j) | (LOGN'(1) << s);
  endfunction

  // tw = k << (LOGN-1-s); k < 2^s so the result always fits in TW_W bits.
  function automatic logic [TW_W-1:0] tw_of(input logic [LOGN-1:0] s,
                                            input logic [TW_W-1:0] j);
    logic [LOGN-1:0] k;
    k = LOGN'(j) & low_mask(s);
    return TW_W'(k << (S_LAST - s));
  endfunction

  // Issue strobe: a pair goes out in every ISSUE cycle unless held.
`ifdef NTT_SCHED_STALL_EN
  assign issue_s = issue_r & ~hold;
`else
  assign issue_s = issue_r;
`endif

  // Next-state logic for the stage / pair / drain counters.
  always_comb begin
    state_nx_s = state_r;
    stage_nx_s = stage_r;
    j_nx_s     = j_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = ISSUE;
          stage_nx_s = '0;
          j_nx_s     = '0;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ISSUE: begin
        if (issue_s) begin
          if (j_r == J_LAST) begin
            state_nx_s = DRAIN;
            cnt_nx_s   = '0;
          end else begin
            j_nx_s = j_r + TW_W'(1);
          end
        end else begin
          state_nx_s = ISSUE;
        end
      end
      DRAIN: begin
        // Wait until the stage's last write has left the delay line.
        if (cnt_r == C_LAST) begin
          if (stage_r == S_LAST) begin
            state_nx_s = FIN;
          end else begin
            state_nx_s = ISSUE;
            stage_nx_s = stage_r + LOGN'(1);
            j_nx_s     = '0;
          end
        end else begin
          cnt_nx_s = cnt_r + CW'(1);
        end
      end
      FIN: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Control registers and read-address registers (loaded for the upcoming pair).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      stage_r <= '0;
      j_r     <= '0;
      cnt_r   <= '0;
      issue_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      rd_x_r  <= '0;
      rd_y_r  <= '0;
      tw_r    <= '0;
    end else begin
      state_r <= state_nx_s;
      stage_r <= stage_nx_s;
      j_r     <= j_nx_s;
      cnt_r   <= cnt_nx_s;
      issue_r <= (state_nx_s == ISSUE);
      busy_r  <= (state_nx_s == ISSUE) || (state_nx_s == DRAIN);
      done_r  <= (state_nx_s == FIN);
      if (state_nx_s == ISSUE) begin
        rd_x_r <= addr_x(stage_nx_s, j_nx_s);
        rd_y_r <= addr_y(stage_nx_s, j_nx_s);
        tw_r   <= tw_of(stage_nx_s, j_nx_s);
      end else begin
        rd_x_r <= rd_x_r;
        rd_y_r <= rd_y_r;
        tw_r   <= tw_r;
      end
    end
  end

  // Delay line carrying the issue strobe and read addresses to the write side.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_dly_r <= '0;
      for (int i = 0; i < DLY; i++) begin
        x_dly_r[i] <= '0;
        y_dly_r[i] <= '0;
      end
    end else begin
      en_dly_r[0] <= issue_s;
      x_dly_r[0]  <= rd_x_r;
      y_dly_r[0]  <= rd_y_r;
      for (int i = 1; i < DLY; i++) begin
        en_dly_r[i] <= en_dly_r[i-1];
        x_dly_r[i]  <= x_dly_r[i-1];
        y_dly_r[i]  <= y_dly_r[i-1];
      end
    end
  end

  // Sticky cross-check of the butterfly valid against our own write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | (bf_valid ^ en_dly_r[DLY-1]);
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign stage     = stage_r;
  assign rd_en     = issue_s;
  assign rd_addr_x = rd_x_r;
  assign rd_addr_y = rd_y_r;
  assign tw_addr   = tw_r;
  assign bf_en     = en_dly_r[RD_LAT-1];
  assign wr_en     = en_dly_r[DLY-1];
  assign wr_addr_x = x_dly_r[DLY-1];
  assign wr_addr_y = y_dly_r[DLY-1];
  assign err       = err_r;

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
module tb_ntt_stage_scheduler;
  localparam int LOGN = 3, BF_LAT = 3, RD_LAT = 1, TW_W = 2;
  localparam int HALF_N = 4, DLY = RD_LAT + BF_LAT;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, kill = 1'b0;
  logic busy, done, rd_en, bf_en, bf_valid, wr_en, err;
  logic [LOGN-1:0] stage, rd_addr_x, rd_addr_y, wr_addr_x, wr_addr_y;
  logic [TW_W-1:0] tw_addr;
  logic [2:0] bfd;
`ifdef NTT_SCHED_STALL_EN
  logic hold = 1'b0;
`endif

  typedef struct {
    logic [LOGN-1:0] x, y, s;
    logic [TW_W-1:0] tw;
    int cyc;
  } pair_t;

  pair_t rd_q[$];
  pair_t wr_q[$];
  int total = 0, bad = 0;

  ntt_stage_scheduler #(.LOGN(LOGN), .BF_LAT(BF_LAT), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef NTT_SCHED_STALL_EN
    .hold(hold),
`endif
    .busy(busy), .done(done), .stage(stage), .rd_en(rd_en),
    .rd_addr_x(rd_addr_x), .rd_addr_y(rd_addr_y), .tw_addr(tw_addr),
    .bf_en(bf_en), .bf_valid(bf_valid), .wr_en(wr_en),
    .wr_addr_x(wr_addr_x), .wr_addr_y(wr_addr_y), .err(err)
  );

  always #5 clk = ~clk;

  // Butterfly model: valid is bf_en delayed by BF_LAT, optionally killed.
  always @(posedge clk or negedge reset) begin
    if (!reset) bfd <= 3'b000;
    else        bfd <= {bfd[1:0], bf_en};
  end
  assign bf_valid = bfd[2] & ~kill;

  // Reference schedule written with the arithmetic form of the address rules.
  task automatic build_model();
    pair_t p;
    rd_q.delete();
    wr_q.delete();
    for (int s = 0; s < LOGN; s++) begin
      for (int j = 0; j < HALF_N; j++) begin
        int half, g, k, x;
        half = 1 << s;
        g = j / half;
        k = j % half;
        x = g * 2 * half + k;
        p.x = LOGN'(x);
        p.y = LOGN'(x + half);
        p.s = LOGN'(s);
        p.tw = TW_W'(k << (LOGN - 1 - s));
        p.cyc = 0;
        rd_q.push_back(p);
      end
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_transform(input string tag, input int exp_done,
                               input int hold_a, input int hold_b);
    pair_t p;
    int wr_cnt = 0, last_s0_wr = 0, first_s1_rd = 0;
    bit seen = 1'b0;
    build_model();
    start_pulse();
    for (int c = 1; c <= 60 && !seen; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      // Starts while busy and together with done must be ignored.
      start = (c == 3 || c == exp_done);
`ifdef NTT_SCHED_STALL_EN
      hold = (c == hold_a || c == hold_b);
`endif
      @(negedge clk);
      if (c == 1) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL %s busy_cycle1 got=%b want=1", tag, busy);
        end
      end
      if (rd_en === 1'b1) begin
        total++;
        if (rd_q.size() == 0) begin
          bad++;
          $display("FAIL %s extra_read cycle=%0d", tag, c);
        end else begin
          p = rd_q.pop_front();
          if ({rd_addr_x, rd_addr_y, tw_addr, stage} !== {p.x, p.y, p.tw, p.s}) begin
            bad++;
            $display("FAIL %s read c=%0d got x=%0d y=%0d tw=%0d s=%0d want x=%0d y=%0d tw=%0d s=%0d",
                     tag, c, rd_addr_x, rd_addr_y, tw_addr, stage, p.x, p.y, p.tw, p.s);
          end
          if (p.s == 1 && first_s1_rd == 0) first_s1_rd = c;
          p.cyc = c + DLY;
          wr_q.push_back(p);
        end
      end
      if (wr_en === 1'b1) begin
        total++;
        wr_cnt++;
        if (wr_q.size() == 0) begin
          bad++;
          $display("FAIL %s extra_write cycle=%0d", tag, c);
        end else begin
          p = wr_q.pop_front();
          if (p.s == 0) last_s0_wr = c;
          if ({wr_addr_x, wr_addr_y} !== {p.x, p.y} || c != p.cyc) begin
            bad++;
            $display("FAIL %s write got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                     tag, wr_addr_x, wr_addr_y, c, p.x, p.y, p.cyc);
          end
        end
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        total++;
        if (c != exp_done || busy !== 1'b0) begin
          bad++;
          $display("FAIL %s done_cycle got=%0d busy=%b want=%0d busy=0", tag, c, busy, exp_done);
        end
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
`ifdef NTT_SCHED_STALL_EN
    hold = 1'b0;
`endif
    @(negedge clk);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s done_timeout got=none want=%0d", tag, exp_done);
    end
    total++;
    if ({done, busy, rd_en} !== 3'b000) begin
      bad++;
      $display("FAIL %s after_done got done/busy/rd=%b want=000", tag, {done, busy, rd_en});
    end
    total++;
    if (wr_cnt != 12 || rd_q.size() != 0) begin
      bad++;
      $display("FAIL %s counts got wr=%0d unread=%0d want wr=12 unread=0", tag, wr_cnt, rd_q.size());
    end
    total++;
    if (last_s0_wr == 0 || first_s1_rd <= last_s0_wr) begin
      bad++;
      $display("FAIL %s stage_order got s0_last_wr=%0d s1_first_rd=%0d want wr<rd", tag, last_s0_wr, first_s1_rd);
    end
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL %s err got=%b want=0", tag, err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, rd_en, bf_en, wr_en, err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=000000", {busy, done, rd_en, bf_en, wr_en, err});
    end
    total++;
    if ({stage, rd_addr_x, rd_addr_y, tw_addr, wr_addr_x, wr_addr_y} !== 17'b0) begin
      bad++;
      $display("FAIL reset_addr got=%h want=0", {stage, rd_addr_x, rd_addr_y, tw_addr, wr_addr_x, wr_addr_y});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full();
    run_transform("full", 25, -1, -1);
  endtask

  task automatic test_mid_reset();
    bit done_seen = 1'b0;
    start_pulse();
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (c == 10) reset = 1'b0;
      if (c == 12) reset = 1'b1;
      @(negedge clk);
      if (done === 1'b1) done_seen = 1'b1;
      if (c == 10 || c == 11) begin
        total++;
        if ({busy, done, rd_en, bf_en, wr_en, err, stage, rd_addr_x, rd_addr_y, tw_addr,
             wr_addr_x, wr_addr_y} !== 23'b0) begin
          bad++;
          $display("FAIL mid_reset_outputs c=%0d got busy=%b rd=%b wr=%b stage=%0d want all 0",
                   c, busy, rd_en, wr_en, stage);
        end
      end
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
    end
    total++;
    if (done_seen) begin
      bad++;
      $display("FAIL mid_reset_no_done got=activity want=none");
    end
    run_transform("after_reset", 25, -1, -1);
  endtask

  task automatic test_err();
    bit seen = 1'b0;
    start_pulse();
    for (int c = 1; c <= 60 && !seen; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      kill = (c == 5);
      @(negedge clk);
      if (c == 5 || c == 6) begin
        total++;
        if (err !== (c == 6)) begin
          bad++;
          $display("FAIL err_timing c=%0d got=%b want=%b", c, err, (c == 6));
        end
      end
      if (done === 1'b1) seen = 1'b1;
    end
    kill = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (err !== 1'b1 || !seen) begin
      bad++;
      $display("FAIL err_sticky got err=%b done_seen=%b want err=1 done_seen=1", err, seen);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got=%b want=0", err);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

`ifdef NTT_SCHED_STALL_EN
  task automatic test_hold();
    run_transform("hold", 27, 2, 3);
  endtask
`endif

  initial begin
    test_reset();
    test_full();
    test_mid_reset();
    test_err();
`ifdef NTT_SCHED_STALL_EN
    test_hold();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
